// File: rtl/memory_controller_if.sv
// Data-memory bus between the memory controller and the memory.
//
// Handshake: the master raises mem_req together with mem_we, mem_addr,
// mem_wdata and mem_be, and holds all of them stable until the slave answers
// with mem_ack for exactly the cycle the access completes. mem_ack (and
// mem_rdata for a load) is meaningful only while mem_req=1; at any other time
// the master ignores it.
interface memory_controller_if;
  logic        mem_req;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/memory_controller.sv
// Memory controller between the pipeline memory stage and a word-addressed
// req/ack data bus. Accepts a load/store request, checks funct3 legality and
// alignment, performs one bus access with byte enables, and returns the load
// result aligned and sign/zero-extended. TIMEOUT_CYCLES must be >= 1 and fit
// in CNT_W bits.
module memory_controller #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         memory_addr,
  input  logic [31:0]         data_to_write,
  input  logic [2:0]          funct3,
  output logic [31:0]         read_data_from_memory_controller,
  output logic                stall,
  output logic                done,
  output logic                misaligned_err,
  output logic                illegal_err,
  output logic                timeout_err,
  memory_controller_if.master bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic        req_any;
  logic        f3_legal;
  logic        addr_misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_val;

  assign req_any   = read | write;
  assign state_dbg = state;

  // Pipeline is held while a request waits in IDLE or the bus access is open.
  always_comb begin
    stall = 1'b0;
    if (state == S_BUSY)                 stall = 1'b1;
    else if (state == S_IDLE && req_any) stall = 1'b1;
  end

  // Decode the incoming request: legality, alignment, lane enables and data.
  always_comb begin
    f3_legal        = 1'b0;
    addr_misaligned = 1'b0;
    be_next         = 4'b1111;
    wdata_next      = data_to_write;
    if (write) f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
    else       f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    case (funct3[1:0])
      2'b00: begin
        be_next    = 4'b0001 << memory_addr[1:0];
        wdata_next = {4{data_to_write[7:0]}};
      end
      2'b01: begin
        addr_misaligned = memory_addr[0];
        be_next         = memory_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next      = {2{data_to_write[15:0]}};
      end
      default: begin
        addr_misaligned = (memory_addr[1:0] != 2'b00);
        be_next         = 4'b1111;
        wdata_next      = data_to_write;
      end
    endcase
  end

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    lane_byte = bus.mem_rdata[7:0];
    case (off_q)
      2'd0: lane_byte = bus.mem_rdata[7:0];
      2'd1: lane_byte = bus.mem_rdata[15:8];
      2'd2: lane_byte = bus.mem_rdata[23:16];
      default: lane_byte = bus.mem_rdata[31:24];
    endcase
    lane_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{lane_byte[7]}}, lane_byte};
      3'b100:  load_val = {24'b0, lane_byte};
      3'b001:  load_val = {{16{lane_half[15]}}, lane_half};
      3'b101:  load_val = {16'b0, lane_half};
      default: load_val = bus.mem_rdata;
    endcase
  end

  // Controller FSM with registered bus signals, pulses and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                            <= S_IDLE;
      wait_cnt                         <= '0;
      f3_q                             <= 3'b000;
      off_q                            <= 2'b00;
      read_data_from_memory_controller <= 32'b0;
      done                             <= 1'b0;
      misaligned_err                   <= 1'b0;
      illegal_err                      <= 1'b0;
      timeout_err                      <= 1'b0;
      bus.mem_req                      <= 1'b0;
      bus.mem_we                       <= 1'b0;
      bus.mem_addr                     <= 30'b0;
      bus.mem_wdata                    <= 32'b0;
      bus.mem_be                       <= 4'b0;
    end else begin
      done           <= 1'b0;
      misaligned_err <= 1'b0;
      illegal_err    <= 1'b0;
      timeout_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_any) begin
            if (!f3_legal) begin
              illegal_err <= 1'b1;
              state       <= S_ERR;
            end else if (addr_misaligned) begin
              misaligned_err <= 1'b1;
              state          <= S_ERR;
            end else begin
              // Write wins when both directions are requested.
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= write;
              bus.mem_addr  <= memory_addr[31:2];
              bus.mem_wdata <= wdata_next;
              bus.mem_be    <= be_next;
              f3_q          <= funct3;
              off_q         <= memory_addr[1:0];
              wait_cnt      <= '0;
              state         <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            if (!bus.mem_we) read_data_from_memory_controller <= load_val;
            done     <= 1'b1;
            wait_cnt <= '0;
            state    <= S_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.mem_req <= 1'b0;
            timeout_err <= 1'b1;
            wait_cnt    <= '0;
            state       <= S_ERR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: directed cases from the test plan followed by
// randomized accesses, checked every cycle against a transaction-level model.
module tb_memory_controller;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        read, write;
  logic [31:0] memory_addr, data_to_write;
  logic [2:0]  funct3;
  logic [31:0] read_data_from_memory_controller;
  logic        stall, done, misaligned_err, illegal_err, timeout_err;
  logic [1:0]  state_dbg;

  memory_controller_if bus();

  memory_controller #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
    .clk                              (clk),
    .rst                              (rst),
    .read                             (read),
    .write                            (write),
    .memory_addr                      (memory_addr),
    .data_to_write                    (data_to_write),
    .funct3                           (funct3),
    .read_data_from_memory_controller (read_data_from_memory_controller),
    .stall                            (stall),
    .done                             (done),
    .misaligned_err                   (misaligned_err),
    .illegal_err                      (illegal_err),
    .timeout_err                      (timeout_err),
    .bus                              (bus.master),
    .state_dbg                        (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // expected outputs for the current cycle
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_done, exp_mis, exp_ill, exp_to, exp_req, exp_we;
  logic [29:0] exp_addr;
  logic [31:0] exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] model_rd;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // model: access rules
  function automatic int size_of(input logic [2:0] f);
    case (f)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit legal(input bit is_wr, input logic [2:0] f);
    if (is_wr) return (f == 3'b000 || f == 3'b001 || f == 3'b010);
    return size_of(f) != 0;
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] f, input logic [31:0] a);
    int m;
    m = ((1 << size_of(f)) - 1) << int'(a[1:0]);
    return m[3:0];
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] f, input logic [31:0] d);
    case (size_of(f))
      1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
      2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_of(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] word);
    int sz;
    logic [31:0] mask, v;
    sz   = size_of(f);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    v    = (word >> (8 * int'(a[1:0]))) & mask;
    if ((f == 3'b000 || f == 3'b001) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // scoreboard compare, once per cycle away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("stall", stall, exp_stall);
      cmp("done", done, exp_done);
      cmp("misaligned_err", misaligned_err, exp_mis);
      cmp("illegal_err", illegal_err, exp_ill);
      cmp("timeout_err", timeout_err, exp_to);
      cmp("mem_req", bus.mem_req, exp_req);
      cmp("read_data", read_data_from_memory_controller, model_rd);
      if (exp_req) begin
        cmp("mem_we", bus.mem_we, exp_we);
        cmp("mem_addr", bus.mem_addr, exp_addr);
        cmp("mem_be", bus.mem_be, exp_be);
        if (exp_we) cmp("mem_wdata", bus.mem_wdata, exp_wdata);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle_exp();
    exp_stall = 1'b0; exp_done = 1'b0; exp_mis = 1'b0; exp_ill = 1'b0;
    exp_to = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = 30'b0; exp_wdata = 32'b0; exp_be = 4'b0;
  endtask

  // One pipeline request; waits<0 or >=TO means the bus never acks.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f,
                        input int waits, input logic [31:0] ack_word);
    bit is_wr, bad_f3, bad_align, acked;
    int sz;
    is_wr     = wr;
    sz        = size_of(f);
    bad_f3    = !legal(is_wr, f);
    bad_align = !bad_f3 && sz > 1 && (int'(a[1:0]) % sz != 0);
    read = rd; write = wr; memory_addr = a; data_to_write = d; funct3 = f;
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    set_idle_exp();
    exp_stall = rd | wr;
    step();
    if (!(rd || wr)) return;
    if (bad_f3 || bad_align) begin
      read = 1'b0; write = 1'b0;
      bus.mem_ack = 1'($urandom_range(0, 1));
      set_idle_exp();
      exp_ill = bad_f3;
      exp_mis = bad_align;
      step();
      return;
    end
    exp_stall = 1'b1; exp_req = 1'b1; exp_we = is_wr;
    exp_addr  = a[31:2]; exp_wdata = wdata_of(f, d); exp_be = be_of(f, a);
    acked = 1'b0;
    for (int i = 0; i < TO; i++) begin
      if (i == waits) begin
        bus.mem_ack = 1'b1; bus.mem_rdata = ack_word;
      end else begin
        bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
      end
      step();
      if (i == waits) begin
        acked = 1'b1;
        break;
      end
    end
    set_idle_exp();
    bus.mem_ack   = 1'($urandom_range(0, 1));
    bus.mem_rdata = $urandom;
    if (acked) begin
      exp_done = 1'b1;
      if (!is_wr) model_rd = load_of(f, a, ack_word);
    end else begin
      exp_to = 1'b1;
    end
    step();
  endtask

  logic [31:0] w_pat;
  int          kind, wsel;
  bit          r_rd, r_wr;

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; memory_addr = 32'b0;
    data_to_write = 32'b0; funct3 = 3'b000;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'b0;
    set_idle_exp();
    model_rd = 32'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // LW zero-wait
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b010, 0, 32'hDEAD_BEEF);
    cmp("lw_read_data", read_data_from_memory_controller, 32'hDEAD_BEEF);
    cmp("lw_be_model", be_of(3'b010, 32'h100), 4'b1111);

    // SB with 3 wait states
    access(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 3'b000, 3, $urandom);
    cmp("sb_read_data_kept", read_data_from_memory_controller, 32'hDEAD_BEEF);
    cmp("sb_be_model", be_of(3'b000, 32'h203), 4'b1000);
    cmp("sb_wdata_model", wdata_of(3'b000, 32'hA5), 32'hA5A5_A5A5);

    // load extraction
    w_pat = 32'h80F0_7F81;
    access(1'b1, 1'b0, 32'h0000_0101, 32'h0, 3'b000, 1, w_pat);
    cmp("lb_o1", read_data_from_memory_controller, 32'h0000_007F);
    access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 3'b000, 0, w_pat);
    cmp("lb_o3", read_data_from_memory_controller, 32'hFFFF_FF80);
    access(1'b1, 1'b0, 32'h0000_0103, 32'h0, 3'b100, 2, w_pat);
    cmp("lbu_o3", read_data_from_memory_controller, 32'h0000_0080);
    access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 3'b001, 0, w_pat);
    cmp("lh_o2", read_data_from_memory_controller, 32'hFFFF_80F0);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b101, 0, w_pat);
    cmp("lhu_o0", read_data_from_memory_controller, 32'h0000_7F81);

    // errors and write priority
    access(1'b1, 1'b0, 32'h0000_0102, 32'h0, 3'b010, 0, $urandom);
    cmp("misaligned_keeps_data", read_data_from_memory_controller, 32'h0000_7F81);
    access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 3'b011, 0, $urandom);
    access(1'b0, 1'b1, 32'h0000_0040, 32'h0, 3'b100, 0, $urandom);
    access(1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 3'b010, 1, $urandom);
    cmp("sw_both_keeps_data", read_data_from_memory_controller, 32'h0000_7F81);

    // timeout
    access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, -1, $urandom);

    // reset during the second wait cycle
    read = 1'b1; write = 1'b0; memory_addr = 32'h0000_0080; funct3 = 3'b010;
    bus.mem_ack = 1'b0;
    set_idle_exp(); exp_stall = 1'b1;
    step();
    exp_req = 1'b1; exp_addr = 30'h20; exp_be = 4'b1111;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; read = 1'b0;
    set_idle_exp();
    model_rd = 32'b0;
    step();
    cmp("rst_mid_busy_data", read_data_from_memory_controller, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 3'b010, 0, 32'hCAFE_F00D);
    cmp("lw_after_reset", read_data_from_memory_controller, 32'hCAFE_F00D);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      r_rd = (kind == 1 || kind == 3 || kind >= 5);
      r_wr = (kind == 2 || kind == 3 || kind == 4);
      wsel = $urandom_range(0, 9);
      access(r_rd, r_wr, $urandom, $urandom, 3'($urandom_range(0, 7)),
             (wsel == 9) ? -1 : (wsel % 4), $urandom);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
Sits directly downstream of the pipeline memory stage. It accepts that stage's read/write request (address, store data, access size), drives a word-addressed req/ack data-memory bus with byte enables, and returns load data aligned and sign/zero-extended to read_data_from_memory_controller. It stalls the pipeline while an access is outstanding and flags misaligned, illegal or timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without mem_ack before a timeout error (must be ≥1)
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
read  input  1  load request from memory stage
write  input  1  store request from memory stage
memory_addr  input  32  byte address
data_to_write  input  32  store data, LSB-aligned
funct3  input  3  RISC-V size/sign field (000 B, 001 H, 010 W, 100 BU, 101 HU)
read_data_from_memory_controller  output  32  extended load result
stall  output  1  hold pipeline
done  output  1  one-cycle pulse: access complete
misaligned_err  output  1  one-cycle pulse
illegal_err  output  1  one-cycle pulse: bad funct3
timeout_err  output  1  one-cycle pulse
mem_req  output  1  bus request
mem_we  output  1  bus write
mem_addr  output  30  word address (byte addr[31:2])
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_rdata  input  32  bus read word
mem_ack  input  1  bus completion, valid only while mem_req=1

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high. All state updates happen on posedge clk.
- Reset: state IDLE; counter 0; read_data 0; all other registered outputs 0. A reset during BUSY drops mem_req in the cycle after the reset edge and discards the access. No done or err pulse is generated.
- FSM states: IDLE, BUSY, DONE, ERR.
- IDLE, request sampled:
  - write has priority if read and write are both 1.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010. Any other value → ERR with illegal_err.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0 → ERR with misaligned_err.
  - Otherwise latch address, data, funct3 and direction, then → BUSY.
- stall (combinational): 1 in IDLE when read|write is asserted; 1 in BUSY; 0 in DONE and ERR.
- BUSY:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata are held stable.
  - On mem_ack: capture the load result and → DONE.
  - Otherwise the counter increments. Reaching TIMEOUT_CYCLES → ERR with timeout_err.
  - mem_ack in the first BUSY cycle is legal (zero-wait bus).
- DONE: done=1 for one cycle, then → IDLE. The pipeline advances on this edge; the next request is sampled in the following IDLE cycle.
- ERR: the asserted err pulse lasts one cycle; stall=0; read_data unchanged; then → IDLE. No bus request is issued for an errored access.
- Latency: request seen at cycle N → mem_req at N+1 → (zero wait) done and read_data valid at N+2. Each wait state adds one cycle.
- Byte enables (o = addr[1:0]):
  - B: 0001<<o
  - H: 0011 (o=0) or 1100 (o=2)
  - W: 1111
  - Loads also drive mem_be.
- Store data: B replicates byte[7:0] on all four lanes; H replicates [15:0] on both halves; W passes through.
- Load extraction (byte lane = mem_rdata[8*o+7 : 8*o]; halfword = lane 0 or 2):
  - B sign-extends, BU zero-extends.
  - H sign-extends, HU zero-extends.
  - W passes through.
- read_data_from_memory_controller updates only on a load ack; stores leave it unchanged.
- mem_ack outside BUSY is ignored.

Test Plan:
- Reset then LW: read=1, addr=0x100, funct3=010, mem_ack immediate with rdata 0xDEADBEEF → mem_addr=0x40, mem_be=1111, mem_we=0; done and read_data=0xDEADBEEF at N+2; stall high N..N+1.
- SB: addr=0x203, data=0x000000A5, 3 wait states → mem_be=1000, mem_wdata=0xA5A5A5A5, mem_we=1, mem_req held 4 cycles; read_data unchanged.
- LB/LBU/LH/LHU: rdata 0x80F0_7F81 → LB@o=1 gives 0x0000007F; LB@o=3 gives 0xFFFFFF80; LBU@o=3 gives 0x00000080; LH@o=2 gives 0xFFFF80F0; LHU@o=0 gives 0x00007F81.
- Errors: LW@0x102 → misaligned_err pulse with no mem_req. funct3=011 → illegal_err. SW with read=write=1 → store performed (mem_we=1).
- Timeout: TIMEOUT_CYCLES=4 and mem_ack never asserted → mem_req for 4 cycles, then timeout_err pulse and stall=0, then IDLE.
- Reset mid-BUSY: rst at second wait cycle → mem_req=0 next cycle, no done, read_data=0; a later LW completes normally.
